// File: rtl/lh_msg_framer_if.sv
`default_nettype none
// ============================================================================
//  Module      : lh_msg_framer_if
//  Description : Bus bundle between the message source / hash core and the
//                light-hash message framer.
//                  in_char/in_valid/in_last/in_ready : byte stream from source
//                  ptxt_char/ptxt_valid              : framed bytes to core
//                  digest_ready                      : core digest available
//                master = environment (source + core), slave = framer.
//  Revision    : 1.0  initial release
// ============================================================================
interface lh_msg_framer_if;
    logic [7:0] in_char;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] ptxt_char;
    logic       ptxt_valid;
    logic       digest_ready;

    modport master (
        output in_char, in_valid, in_last, digest_ready,
        input  in_ready, ptxt_char, ptxt_valid
    );

    modport slave (
        input  in_char, in_valid, in_last, digest_ready,
        output in_ready, ptxt_char, ptxt_valid
    );
endinterface
`default_nettype wire

// File: rtl/lh_msg_framer.sv
`default_nettype none
// ============================================================================
//  Module      : lh_msg_framer
//  Description : Upstream front-end of the light-hash core. Buffers incoming
//                message bytes in a small FIFO, drops characters outside
//                [0-9A-Za-z] and frames each message to the core as
//                START_BYTE, accepted chars (at most MAX_LEN), FINISH_BYTE.
//                After FINISH it waits for digest_ready (bounded by TIMEOUT)
//                before framing the next message.
//  Ports       : clk, rst_n (async, active-low)
//                bus          : lh_msg_framer_if.slave (input stream, core side)
//                busy         : framer is not idle
//                err_char     : pulse, accepted byte dropped as invalid
//                err_overflow : sticky, current message truncated
//                err_timeout  : pulse, digest wait expired
//  Revision    : 1.0  initial release
// ============================================================================
module lh_msg_framer #(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         MAX_LEN     = 64,
    parameter int         TIMEOUT     = 255,
    parameter logic [7:0] START_BYTE  = 8'hFF,
    parameter logic [7:0] FINISH_BYTE = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    lh_msg_framer_if.slave   bus,
    output logic             busy,
    output logic             err_char,
    output logic             err_overflow,
    output logic             err_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;              // extra bit separates full from empty
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STREAM   = 2'd1,
        ST_SEND_FIN = 2'd2,
        ST_WAIT_DIG = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO: entry = {has_char, last, char[7:0]}
    // ------------------------------------------------------------------
    logic [9:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          char_ok;
    logic          accept;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [9:0]    wr_entry;
    logic [9:0]    rd_entry;

    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    assign char_ok = ((bus.in_char >= 8'h30) && (bus.in_char <= 8'h39)) ||
                     ((bus.in_char >= 8'h41) && (bus.in_char <= 8'h5A)) ||
                     ((bus.in_char >= 8'h61) && (bus.in_char <= 8'h7A));

    // Readiness depends only on fullness; a same-cycle pop does not free a slot.
    assign bus.in_ready = !fifo_full;
    assign accept       = bus.in_valid && !fifo_full;

    // An invalid byte is only stored when it ends a message, so the frame
    // still gets closed; it carries no character.
    assign fifo_wr  = accept && (char_ok || bus.in_last);
    assign wr_entry = char_ok ? {1'b1, bus.in_last, bus.in_char}
                              : {1'b0, 1'b1, 8'h00};
    assign rd_entry = fifo_mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + PW'(fifo_wr);
    assign rd_ptr_d = rd_ptr_q + PW'(fifo_rd);

    // Storage needs no reset: pointers alone define validity.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [7:0]    ptxt_char_q, ptxt_char_d;
    logic          ptxt_valid_q, ptxt_valid_d;
    logic [LW-1:0] len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_char_q, err_char_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_timeout_q, err_timeout_d;

    assign err_char_d = accept && !char_ok;

    always_comb begin
        state_d        = state_q;
        ptxt_char_d    = ptxt_char_q;
        ptxt_valid_d   = 1'b0;
        len_d          = len_q;
        timer_d        = timer_q;
        err_overflow_d = err_overflow_q;
        err_timeout_d  = 1'b0;
        fifo_rd        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    ptxt_char_d    = START_BYTE;
                    ptxt_valid_d   = 1'b1;
                    len_d          = '0;
                    err_overflow_d = 1'b0;
                    state_d        = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    if (rd_entry[9]) begin
                        if (len_q != LW'(MAX_LEN)) begin
                            ptxt_char_d  = rd_entry[7:0];
                            ptxt_valid_d = 1'b1;
                            len_d        = len_q + LW'(1);
                        end else begin
                            // Length budget exhausted: swallow the char.
                            err_overflow_d = 1'b1;
                        end
                    end
                    if (rd_entry[8]) begin
                        state_d = ST_SEND_FIN;
                    end
                end
            end

            ST_SEND_FIN: begin
                ptxt_char_d  = FINISH_BYTE;
                ptxt_valid_d = 1'b1;
                timer_d      = '0;
                state_d      = ST_WAIT_DIG;
            end

            ST_WAIT_DIG: begin
                // Digest wins over a simultaneous expiry.
                if (bus.digest_ready) begin
                    state_d = ST_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ptxt_char_q    <= 8'h00;
            ptxt_valid_q   <= 1'b0;
            len_q          <= '0;
            timer_q        <= '0;
            err_char_q     <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ptxt_char_q    <= ptxt_char_d;
            ptxt_valid_q   <= ptxt_valid_d;
            len_q          <= len_d;
            timer_q        <= timer_d;
            err_char_q     <= err_char_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.ptxt_char  = ptxt_char_q;
    assign bus.ptxt_valid = ptxt_valid_q;
    assign busy           = (state_q != ST_IDLE);
    assign err_char       = err_char_q;
    assign err_overflow   = err_overflow_q;
    assign err_timeout    = err_timeout_q;

endmodule
`default_nettype wire
